dmem_sram_bridge: RTL
=====================

// Module: dmem_sram_bridge
// PURPOSE
//  Data-side bridge between the mem stage and the SRAM-like data bus (DCache/uncached path).
//  Turns the mem stage's combinational d_* request into one req/addr_ok/data_ok transaction.
//  Holds the pipeline via d_stall until the transaction completes.
//  Latches read data so d_rdata stays stable until the mem stage advances.
// PARAMETERS
//  ADDR_W  32  address width
//  DATA_W  32  data width; DATA_W/8 byte strobes
// PORTS
//  clk            in   1       single clock, all state on rising edge
//  resetn         in   1       synchronous, active-low reset
//  d_en           in   2       00 none, 01 load, 10 store, 11 treated as none
//  d_addr         in   ADDR_W  byte address
//  d_wdata        in   DATA_W  store data, already lane-replicated by mem stage
//  d_size         in   3       000 byte, 001 half, 010 word
//  w_byte_select  in   4       store byte strobes; ignored for loads
//  mem_advance    in   1       mem-stage instruction moves to wb this cycle
//  flush          in   1       cancel the mem-stage instruction (exception/eret)
//  d_rdata        out  DATA_W  raw loaded word (lane select/extension done in mem stage)
//  d_stall        out  1       hold pipeline: request not yet complete
//  data_req       out  1       bus request valid
//  data_wr        out  1       1 store, 0 load
//  data_size      out  2       d_size[1:0]
//  data_addr      out  ADDR_W  bus address
//  data_wdata     out  DATA_W  bus write data
//  data_wstrb     out  4       byte strobes (0000 for loads)
//  data_rdata     in   DATA_W  bus read data, valid with data_ok
//  data_addr_ok   in   1       address accepted this cycle (req && addr_ok = handshake)
//  data_ok        in   1       transaction complete; exactly one per accepted address
// BEHAVIOUR
//  FSM: IDLE, REQ, WAIT, DONE, DRAIN. Reset (resetn=0 at edge): IDLE, data_req=0,
//   data_wr=0, data_size=0, data_addr=0, data_wdata=0, data_wstrb=0, d_rdata=0, d_stall=0.
//  Reset mid-transaction abandons it unconditionally; the bus is reset in the same cycle.
//  IDLE: d_en in {01,10} && !flush -> REQ; capture addr/wdata/size/wstrb/wr into regs.
//   d_stall=1 combinationally in that same cycle.
//  REQ: data_req=1 from captured regs; addr_ok -> WAIT; addr_ok && data_ok same cycle -> DONE.
//  WAIT: data_req=0; data_ok -> DONE, d_rdata <= data_rdata (loads only; stores keep old).
//  DONE: d_stall=0; d_rdata stable; mem_advance -> IDLE; otherwise stay (no re-issue
//   while the pipeline is held by another stage).
//  d_stall = 1 in IDLE-with-request, REQ, WAIT, DRAIN; 0 otherwise.
//  Minimum latency: request at cycle 0, addr_ok at 1, data_ok at 2 -> d_stall low at 3.
//  flush: IDLE/DONE -> IDLE, no request issued; REQ without addr_ok -> IDLE (req dropped);
//   REQ with addr_ok, or WAIT -> DRAIN. DRAIN: data_req=0, d_stall=1, discard data;
//   data_ok -> IDLE. No new request accepted until DRAIN exits.
//  data_ok outside WAIT/REQ/DRAIN is a bus protocol error: ignored, no state change.
//  Bus outputs are registered; captured request never changes while data_req=1.
// CONFIGURATION
//  DMEM_ADDR_MAP_EN defined: data_addr = fixed MIPS map: kseg0/kseg1 (0x8000_0000-
//   0xBFFF_FFFF) -> addr & 0x1FFF_FFFF; other segments pass through unchanged.
//  Not defined: data_addr = d_addr unchanged (translation done downstream by MMU).
// STRUCTURE
//  Shared package: FSM state enum; d_en encodings (EN_NONE/EN_LOAD/EN_STORE);
//   size encodings (SZ_B/SZ_H/SZ_W).
//  Sub-module: dmem_addr_map (combinational segment map), instantiated only under the macro.
// TESTING
//  Load 0x0000_1004, addr_ok cycle 1, data_ok+rdata=0xDEADBEEF cycle 2 -> stall 3 cycles,
//   then d_rdata=0xDEADBEEF held until mem_advance.
//  Store word 0x1234_5678, wstrb=1111 -> data_wr=1, data_wstrb=1111, wdata stable until addr_ok.
//  addr_ok held low 5 cycles -> data_req stays 1, request fields unchanged, d_stall=1.
//  flush in WAIT, data_ok 3 cycles later -> DRAIN, d_rdata unchanged, then IDLE, stall=0.
//  DONE with mem_advance=0 for 4 cycles -> no second data_req; back-to-back load issues next.
//  resetn=0 during WAIT -> all outputs 0 next cycle; with DMEM_ADDR_MAP_EN,
//   load 0xBFC0_0000 -> data_addr=0x1FC0_0000.

Source files
------------

// File: rtl/dmem_sram_bridge_pkg.sv
// Shared encodings for the data-side SRAM bridge: FSM states, d_en and d_size codes.
package dmem_sram_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  localparam logic [1:0] EN_NONE  = 2'b00;
  localparam logic [1:0] EN_LOAD  = 2'b01;
  localparam logic [1:0] EN_STORE = 2'b10;

  localparam logic [2:0] SZ_B = 3'b000;
  localparam logic [2:0] SZ_H = 3'b001;
  localparam logic [2:0] SZ_W = 3'b010;

endpackage

// File: rtl/dmem_addr_map.sv
// Fixed MIPS segment map: kseg0/kseg1 fold onto physical low 512MB, others pass through.
module dmem_addr_map #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] vaddr,
  output logic [ADDR_W-1:0] paddr
);

  always_comb begin
    paddr = vaddr;
    if (vaddr[ADDR_W-1 -: 2] == 2'b10)
      paddr = vaddr & {3'b000, {(ADDR_W-3){1'b1}}};
  end

endmodule

// File: rtl/dmem_sram_bridge.sv
// Mem-stage to SRAM-like data bus bridge; one req/addr_ok/data_ok transaction per access.
// Define DMEM_ADDR_MAP_EN to apply the fixed kseg0/kseg1 address map to data_addr.
module dmem_sram_bridge
  import dmem_sram_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [1:0]          d_en,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [2:0]          d_size,
  input  logic [DATA_W/8-1:0] w_byte_select,
  input  logic                mem_advance,
  input  logic                flush,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_stall,
  output logic                data_req,
  output logic                data_wr,
  output logic [1:0]          data_size,
  output logic [ADDR_W-1:0]   data_addr,
  output logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W/8-1:0] data_wstrb,
  input  logic [DATA_W-1:0]   data_rdata,
  input  logic                data_addr_ok,
  input  logic                data_ok
);

  state_e              state_q, state_d;
  logic                req_q, req_d;
  logic                wr_q, wr_d;
  logic [1:0]          size_q, size_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]   map_addr;
  logic                new_req;
  logic                unused_size_hi;

`ifdef DMEM_ADDR_MAP_EN
  dmem_addr_map #(.ADDR_W(ADDR_W)) u_addr_map (
    .vaddr (d_addr),
    .paddr (map_addr)
  );
`else
  assign map_addr = d_addr;
`endif

  assign unused_size_hi = d_size[2];
  assign new_req = ((d_en == EN_LOAD) || (d_en == EN_STORE)) && !flush;

  always_comb begin
    state_d = state_q;
    req_d   = 1'b0;
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    d_stall = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (new_req) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          wr_d    = (d_en == EN_STORE);
          size_d  = d_size[1:0];
          addr_d  = map_addr;
          wdata_d = d_wdata;
          wstrb_d = (d_en == EN_STORE) ? w_byte_select : '0;
          d_stall = 1'b1;
        end
      end
      ST_REQ: begin
        d_stall = 1'b1;
        if (data_addr_ok) begin
          // An accepted address owes one data_ok; if it already arrived there is nothing to drain.
          if (flush)        state_d = data_ok ? ST_IDLE : ST_DRAIN;
          else if (data_ok) begin
            state_d = ST_DONE;
            if (!wr_q) rdata_d = data_rdata;
          end else          state_d = ST_WAIT;
        end else if (flush) state_d = ST_IDLE;
        else                req_d   = 1'b1;
      end
      ST_WAIT: begin
        d_stall = 1'b1;
        if (flush)        state_d = data_ok ? ST_IDLE : ST_DRAIN;
        else if (data_ok) begin
          state_d = ST_DONE;
          if (!wr_q) rdata_d = data_rdata;
        end
      end
      ST_DONE: begin
        if (flush || mem_advance) state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        d_stall = 1'b1;
        if (data_ok) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
    end
  end

  assign data_req   = req_q;
  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_addr  = addr_q;
  assign data_wdata = wdata_q;
  assign data_wstrb = wstrb_q;
  assign d_rdata    = rdata_q;

endmodule
